clks_alot_generator: RTL and testbench
======================================

# clks_alot_generator

- Transmit-side counterpart of the clock-recovery path: synthesises an output clock (single-ended or differential) from programmable high/low half-rates, counted in `clk_i` cycles.
- Drives `recovery_drivers_s` pins and reports `generated_events_s` and `status_s` per cycle.
- Supports a glitch-free, period-boundary reconfiguration handshake and a parkable pause.
- Sits beside the recovery block, so a local or forwarded clock can be produced with the same rate semantics the receiver checks.

## Interface
- `RATE_COUNTER_WIDTH`, default `clks_alot_p::RATE_COUNTER_WIDTH` (32): width of rate and duration counters.

Ports:
- `clk_i`  in  1  system clock.
- `rst_n_i`  in  1  asynchronous active-low reset.
- `enable_i`  in  1  run request; level-sensitive.
- `differential_en_i`  in  1  when 1, secondary driver = ~primary; when 0, secondary held 0.
- `pause_req_i`  in  1  park clock low at next period boundary; level-sensitive.
- `conf_valid_i`  in  1  new rate configuration offered.
- `conf_ready_o`  out  1  configuration accepted when `conf_valid_i && conf_ready_o`.
- `even_50_50_en_i`  in  1  when 1, `high_rate_i` is used for both halves.
- `high_rate_i`  in  RATE_COUNTER_WIDTH  high half-period in `clk_i` cycles; 0 is treated as 1.
- `low_rate_i`  in  RATE_COUNTER_WIDTH  low half-period in `clk_i` cycles; 0 is treated as 1.
- `drivers_o`  out  `recovery_drivers_s`  output pins.
- `events_o`  out  `generated_events_s`  per-cycle phase events.
- `status_o`  out  `status_s`  pause and lock status.

## Operation
FSM states: IDLE, HIGH, LOW, PAUSED. Active rates are held in registers; pending rates in a shadow register with a `pending` flag.

- `conf_ready_o = !pending`.
  - On accept, the rates are latched into the shadow register (after 50/50 and zero-clamp are applied) and `pending` is set.
  - Pending is copied to active:
    - immediately in IDLE or PAUSED;
    - otherwise on the last cycle of LOW.
  - `pending` clears on the copy.
- IDLE:
  - Primary is 0.
  - Goes to HIGH when `enable_i` is 1, a valid active config exists (at least one accept since reset), and `pause_req_i` is 0.
- HIGH:
  - Down-counter loads `high-1`.
  - At 0, goes to LOW and loads `low-1`.
- LOW: at 0 (period boundary), the next state is decided in priority order:
  1. `!enable_i` → IDLE.
  2. `pause_req_i` → PAUSED.
  3. Otherwise → HIGH.
- A period is never truncated; enable, pause and config changes take effect only at a boundary.
- PAUSED:
  - Primary is held 0.
  - `pause_duration` counts elapsed equivalent output periods (`high+low` `clk_i` cycles each), saturating at all-ones; it clears on entering PAUSED.
  - Goes to HIGH when `pause_req_i` drops and `enable_i` is 1; goes to IDLE if `enable_i` drops.
- Events (aligned with `drivers_o`, exactly one asserted per cycle):
  - `rising_edge`: first HIGH cycle.
  - `steady_high`: other HIGH cycles.
  - `falling_edge`: first LOW cycle.
  - `steady_low`: other LOW cycles, and all IDLE/PAUSED cycles.
  - Rate 1: each HIGH/LOW cycle is an edge cycle, so the steady events are never asserted.
- Status:
  - `locked` sets on the first `rising_edge` and clears on entry to IDLE.
  - `pause_active` = state is PAUSED.
  - `status_o.pause_duration` holds its last value after a resume until the next pause.

## Timing
- Reset values:
  - `drivers_o` = 0/0.
  - `events_o.steady_low` = 1; all other event bits 0.
  - `status_o` all 0.
  - `conf_ready_o` = 1.
  - State IDLE; no valid config.
- All outputs are registered.
- Start latency: `enable_i` sampled high in IDLE with a valid config → primary is 1 on the next cycle.
- Config accepted in IDLE with `enable_i` already high → first rising edge 2 cycles after the accept edge.
- Output period = active `high+low` cycles exactly; there is no drift or jitter.
- Simultaneous accept and boundary in LOW: the new config loads into pending and applies at the following boundary.
- Async reset mid-period forces IDLE and the primary low immediately; this may produce a runt pulse, which is accepted.

## Structure
- Add to `clks_alot_p`: `gen_state_e` (IDLE/HIGH/LOW/PAUSED) and `gen_rate_conf_s` {`high_rate`, `low_rate`}.
- Reuse existing `recovery_drivers_s`, `generated_events_s`, `status_s`.
- One sub-module is natural: `clks_alot_half_counter`, a loadable down-counter with a zero flag, instanced for the phase timer and the pause-period timer.

## Test plan
- Config high=3, low=2, enable: primary pattern `11100` repeating; events R,SH,SH,F,SL; `locked`=1 from first R.
- `even_50_50_en`=1, high=4, low=9: period 8, 4/4 duty; `differential_en_i`=1 gives secondary = ~primary every cycle.
- Mid-HIGH, offer high=1, low=1:
  - `conf_ready_o` drops for the cycles until the LOW-end boundary;
  - the next period is `10`;
  - only R/F events thereafter.
- `pause_req_i` raised mid-HIGH with high=2, low=2:
  - completes the period, then parks low;
  - after 12 cycles, `pause_duration`=3;
  - releasing pause → R on the next cycle.
- `enable_i` dropped mid-LOW: the current period finishes, then IDLE, `locked`=0; rates 0/0 configured → behaves as 1/1.
- Assert `rst_n_i` mid-HIGH: outputs go to reset values without waiting for `clk_i`; restart requires a new config accept.

Source files
------------

// File: rtl/clks_alot_p.sv
// Shared types and constants for the clks_alot clock recovery / generation blocks.
package clks_alot_p;

  localparam int unsigned RATE_COUNTER_WIDTH = 32;

  typedef enum logic [1:0] {
    GEN_IDLE,
    GEN_HIGH,
    GEN_LOW,
    GEN_PAUSED
  } gen_state_e;

  typedef struct packed {
    logic [RATE_COUNTER_WIDTH-1:0] high_rate;
    logic [RATE_COUNTER_WIDTH-1:0] low_rate;
  } gen_rate_conf_s;

  typedef struct packed {
    logic primary;
    logic secondary;
  } recovery_drivers_s;

  typedef struct packed {
    logic rising_edge;
    logic steady_high;
    logic falling_edge;
    logic steady_low;
  } generated_events_s;

  typedef struct packed {
    logic                          locked;
    logic                          pause_active;
    logic [RATE_COUNTER_WIDTH-1:0] pause_duration;
  } status_s;

endpackage

// File: rtl/clks_alot_half_counter.sv
// Loadable down-counter with a zero flag; stops at zero until reloaded.
module clks_alot_half_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;

  // Load has priority over decrement; the count never wraps below zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/clks_alot_generator.sv
// Clock generator: builds a single-ended or differential output clock from
// programmable high/low half-periods, with boundary-aligned reconfiguration
// and a parkable pause that counts elapsed equivalent periods.
module clks_alot_generator
  import clks_alot_p::*;
#(
  parameter int unsigned RATE_COUNTER_WIDTH = clks_alot_p::RATE_COUNTER_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          enable_i,
  input  logic                          differential_en_i,
  input  logic                          pause_req_i,
  input  logic                          conf_valid_i,
  output logic                          conf_ready_o,
  input  logic                          even_50_50_en_i,
  input  logic [RATE_COUNTER_WIDTH-1:0] high_rate_i,
  input  logic [RATE_COUNTER_WIDTH-1:0] low_rate_i,
  output recovery_drivers_s             drivers_o,
  output generated_events_s             events_o,
  output status_s                       status_o
);

  localparam int unsigned W  = RATE_COUNTER_WIDTH;
  localparam int unsigned PW = RATE_COUNTER_WIDTH + 1;
  localparam logic [W-1:0]  ONE  = W'(1);
  localparam logic [PW-1:0] PONE = PW'(1);

  gen_state_e        state_q, state_d;
  logic [W-1:0]      act_high_q, act_low_q, shd_high_q, shd_low_q;
  logic              valid_q, pending_q;
  recovery_drivers_s drivers_q;
  generated_events_s events_q;
  status_s           status_q;

  logic [W-1:0]  conf_high, conf_low, eff_high, eff_low, phase_val;
  logic [PW-1:0] pause_val;
  logic          accept, copy, phase_zero, pause_zero;
  logic          phase_load, pause_load, pause_tick, phase_run, pause_run;

  assign conf_high = (high_rate_i == '0) ? ONE : high_rate_i;
  assign conf_low  = even_50_50_en_i ? conf_high : ((low_rate_i == '0) ? ONE : low_rate_i);

  assign accept = conf_valid_i && !pending_q;
  // A pending config is promoted whenever no period is in flight, or on the
  // last LOW cycle; the rates used for this cycle's loads follow the promotion.
  assign copy = pending_q && ((state_q == GEN_IDLE) || (state_q == GEN_PAUSED) ||
                              ((state_q == GEN_LOW) && phase_zero));
  assign eff_high  = copy ? shd_high_q : act_high_q;
  assign eff_low   = copy ? shd_low_q  : act_low_q;
  assign pause_val = {1'b0, eff_high} + {1'b0, eff_low} - PONE;
  assign phase_run = (state_q == GEN_HIGH) || (state_q == GEN_LOW);
  assign pause_run = (state_q == GEN_PAUSED);

  clks_alot_half_counter #(.WIDTH(W)) u_phase_timer (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (phase_load),
    .load_val_i (phase_val),
    .dec_i      (phase_run),
    .zero_o     (phase_zero)
  );

  clks_alot_half_counter #(.WIDTH(PW)) u_pause_timer (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (pause_load),
    .load_val_i (pause_val),
    .dec_i      (pause_run),
    .zero_o     (pause_zero)
  );

  // Next-state and timer-load decisions; transitions out of a period only at its end.
  always_comb begin
    state_d    = state_q;
    phase_load = 1'b0;
    phase_val  = eff_high - ONE;
    pause_load = 1'b0;
    pause_tick = 1'b0;
    case (state_q)
      GEN_IDLE: begin
        if (enable_i && valid_q && !pause_req_i) begin
          state_d    = GEN_HIGH;
          phase_load = 1'b1;
        end
      end
      GEN_HIGH: begin
        if (phase_zero) begin
          state_d    = GEN_LOW;
          phase_load = 1'b1;
          phase_val  = eff_low - ONE;
        end
      end
      GEN_LOW: begin
        if (phase_zero) begin
          if (!enable_i) begin
            state_d = GEN_IDLE;
          end else if (pause_req_i) begin
            state_d    = GEN_PAUSED;
            pause_load = 1'b1;
          end else begin
            state_d    = GEN_HIGH;
            phase_load = 1'b1;
          end
        end
      end
      GEN_PAUSED: begin
        if (!enable_i) begin
          state_d = GEN_IDLE;
        end else if (!pause_req_i) begin
          state_d    = GEN_HIGH;
          phase_load = 1'b1;
        end else if (pause_zero) begin
          pause_load = 1'b1;
          pause_tick = 1'b1;
        end
      end
      default: state_d = GEN_IDLE;
    endcase
  end

  // State, rate registers and registered outputs, all derived from the next state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= GEN_IDLE;
      act_high_q <= '0;
      act_low_q  <= '0;
      shd_high_q <= '0;
      shd_low_q  <= '0;
      valid_q    <= 1'b0;
      pending_q  <= 1'b0;
      drivers_q  <= '0;
      events_q   <= '{rising_edge: 1'b0, steady_high: 1'b0, falling_edge: 1'b0, steady_low: 1'b1};
      status_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        shd_high_q <= conf_high;
        shd_low_q  <= conf_low;
        pending_q  <= 1'b1;
      end
      if (copy) begin
        act_high_q <= shd_high_q;
        act_low_q  <= shd_low_q;
        valid_q    <= 1'b1;
        pending_q  <= 1'b0;
      end
      drivers_q.primary   <= (state_d == GEN_HIGH);
      drivers_q.secondary <= differential_en_i && (state_d != GEN_HIGH);
      events_q.rising_edge  <= (state_d == GEN_HIGH) && (state_q != GEN_HIGH);
      events_q.steady_high  <= (state_d == GEN_HIGH) && (state_q == GEN_HIGH);
      events_q.falling_edge <= (state_d == GEN_LOW) && (state_q != GEN_LOW);
      events_q.steady_low   <= (state_d != GEN_HIGH) && !((state_d == GEN_LOW) && (state_q != GEN_LOW));
      if (state_d == GEN_IDLE) begin
        status_q.locked <= 1'b0;
      end else if (state_d == GEN_HIGH) begin
        status_q.locked <= 1'b1;
      end
      status_q.pause_active <= (state_d == GEN_PAUSED);
      if ((state_d == GEN_PAUSED) && (state_q != GEN_PAUSED)) begin
        status_q.pause_duration <= '0;
      end else if (pause_tick && (state_d == GEN_PAUSED) && (status_q.pause_duration != '1)) begin
        status_q.pause_duration <= status_q.pause_duration + 1'b1;
      end
    end
  end

  assign conf_ready_o = !pending_q;
  assign drivers_o    = drivers_q;
  assign events_o     = events_q;
  assign status_o     = status_q;

endmodule

// File: tb/tb_clks_alot_generator.sv
// Self-checking bench for clks_alot_generator: per-cycle expected outputs are
// queued by each scenario and compared one entry per clock.
module tb_clks_alot_generator;
  import clks_alot_p::*;

  logic clk = 1'b0;
  logic rst_n, enable, diff, pause, cvalid, even, cready;
  logic [31:0] hr, lr;
  recovery_drivers_s drv;
  generated_events_s ev;
  status_s st;

  int checks = 0;
  int errors = 0;
  logic [8:0] sb_q[$];
  logic [8:0] exp_v;

  localparam logic [3:0] R = 4'b1000, SH = 4'b0100, F = 4'b0010, SL = 4'b0001;

  clks_alot_generator #(.RATE_COUNTER_WIDTH(32)) dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .enable_i          (enable),
    .differential_en_i (diff),
    .pause_req_i       (pause),
    .conf_valid_i      (cvalid),
    .conf_ready_o      (cready),
    .even_50_50_en_i   (even),
    .high_rate_i       (hr),
    .low_rate_i        (lr),
    .drivers_o         (drv),
    .events_o          (ev),
    .status_o          (st)
  );

  always #5 clk = ~clk;

  // {primary, secondary, rising, steady_high, falling, steady_low, ready, locked, pause_active}
  function automatic logic [8:0] mk(input logic p, input logic s, input logic [3:0] e,
                                    input logic rdy, input logic lk, input logic pa);
    return {p, s, e, rdy, lk, pa};
  endfunction

  function automatic logic [8:0] obs();
    return {drv.primary, drv.secondary, ev.rising_edge, ev.steady_high,
            ev.falling_edge, ev.steady_low, cready, st.locked, st.pause_active};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 0; diff = 0; pause = 0; cvalid = 0; even = 0; hr = '0; lr = '0;
    #12;
    checks++;
    if (obs() !== mk(0, 0, SL, 1, 0, 0) || st.pause_duration !== 32'd0) begin
      errors++;
      $display("FAIL reset got %b dur %0d exp %b dur 0", obs(), st.pause_duration, mk(0, 0, SL, 1, 0, 0));
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    cvalid = 1; hr = 32'd3; lr = 32'd2; enable = 1;
    sb_q.push_back(mk(0, 0, SL, 0, 0, 0));
    sb_q.push_back(mk(0, 0, SL, 1, 0, 0));
    for (int k = 0; k < 2; k++) begin
      sb_q.push_back(mk(1, 0, R, 1, 1, 0));
      sb_q.push_back(mk(1, 0, SH, 1, 1, 0));
      sb_q.push_back(mk(1, 0, SH, 1, 1, 0));
      sb_q.push_back(mk(0, 0, F, 1, 1, 0));
      sb_q.push_back(mk(0, 0, SL, 1, 1, 0));
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) cvalid = 0;
      exp_v = sb_q.pop_front();
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL basic cyc %0d got %b exp %b", i, obs(), exp_v);
      end
    end
  endtask

  task automatic test_even_diff();
    cvalid = 1; even = 1; hr = 32'd4; lr = 32'd9; diff = 1;
    sb_q.push_back(mk(1, 0, R, 0, 1, 0));
    sb_q.push_back(mk(1, 0, SH, 0, 1, 0));
    sb_q.push_back(mk(1, 0, SH, 0, 1, 0));
    sb_q.push_back(mk(0, 1, F, 0, 1, 0));
    sb_q.push_back(mk(0, 1, SL, 0, 1, 0));
    sb_q.push_back(mk(1, 0, R, 1, 1, 0));
    for (int k = 0; k < 3; k++) sb_q.push_back(mk(1, 0, SH, 1, 1, 0));
    sb_q.push_back(mk(0, 1, F, 1, 1, 0));
    for (int k = 0; k < 3; k++) sb_q.push_back(mk(0, 1, SL, 1, 1, 0));
    for (int i = 0; i < 13; i++) begin
      tick();
      if (i == 0) cvalid = 0;
      exp_v = sb_q.pop_front();
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL even_diff cyc %0d got %b exp %b", i, obs(), exp_v);
      end
    end
  endtask

  task automatic test_rate_one();
    sb_q.push_back(mk(1, 0, R, 1, 1, 0));
    for (int k = 0; k < 3; k++) sb_q.push_back(mk(1, 0, SH, 0, 1, 0));
    sb_q.push_back(mk(0, 1, F, 0, 1, 0));
    for (int k = 0; k < 3; k++) sb_q.push_back(mk(0, 1, SL, 0, 1, 0));
    for (int k = 0; k < 4; k++) begin
      sb_q.push_back(mk(1, 0, R, 1, 1, 0));
      sb_q.push_back(mk(0, 1, F, 1, 1, 0));
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 0) begin cvalid = 1; even = 0; hr = 32'd1; lr = 32'd1; end
      if (i == 1) cvalid = 0;
      exp_v = sb_q.pop_front();
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL rate_one cyc %0d got %b exp %b", i, obs(), exp_v);
      end
    end
  endtask

  task automatic test_pause();
    cvalid = 1; hr = 32'd2; lr = 32'd2;
    sb_q.push_back(mk(1, 0, R, 0, 1, 0));
    sb_q.push_back(mk(0, 1, F, 0, 1, 0));
    sb_q.push_back(mk(1, 0, R, 1, 1, 0));
    sb_q.push_back(mk(1, 0, SH, 1, 1, 0));
    sb_q.push_back(mk(0, 1, F, 1, 1, 0));
    sb_q.push_back(mk(0, 1, SL, 1, 1, 0));
    for (int k = 0; k < 13; k++) sb_q.push_back(mk(0, 1, SL, 1, 1, 1));
    sb_q.push_back(mk(1, 0, R, 1, 1, 0));
    sb_q.push_back(mk(1, 0, SH, 1, 1, 0));
    sb_q.push_back(mk(0, 1, F, 1, 1, 0));
    for (int i = 0; i < 22; i++) begin
      tick();
      exp_v = sb_q.pop_front();
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL pause cyc %0d got %b exp %b", i, obs(), exp_v);
      end
      if (i == 6 || i == 9 || i == 10 || i == 18 || i == 20) begin
        checks++;
        if (st.pause_duration !== ((i >= 18) ? 32'd3 : (i == 10) ? 32'd1 : 32'd0)) begin
          errors++;
          $display("FAIL pause_duration cyc %0d got %0d exp %0d", i, st.pause_duration,
                   (i >= 18) ? 3 : (i == 10) ? 1 : 0);
        end
      end
      if (i == 0) cvalid = 0;
      if (i == 2) pause = 1;
      if (i == 18) pause = 0;
    end
  endtask

  task automatic test_disable();
    enable = 0;
    sb_q.push_back(mk(0, 1, SL, 1, 1, 0));
    sb_q.push_back(mk(0, 1, SL, 1, 0, 0));
    sb_q.push_back(mk(0, 1, SL, 0, 0, 0));
    sb_q.push_back(mk(0, 1, SL, 1, 0, 0));
    for (int k = 0; k < 2; k++) begin
      sb_q.push_back(mk(1, 0, R, 1, 1, 0));
      sb_q.push_back(mk(0, 1, F, 1, 1, 0));
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 1) begin cvalid = 1; hr = '0; lr = '0; end
      if (i == 2) cvalid = 0;
      if (i == 3) enable = 1;
      exp_v = sb_q.pop_front();
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL disable cyc %0d got %b exp %b", i, obs(), exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    tick();
    checks++;
    if (obs() !== mk(1, 0, R, 1, 1, 0)) begin
      errors++;
      $display("FAIL pre_reset got %b exp %b", obs(), mk(1, 0, R, 1, 1, 0));
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== mk(0, 0, SL, 1, 0, 0) || st.pause_duration !== 32'd0) begin
      errors++;
      $display("FAIL async_reset got %b dur %0d exp %b dur 0", obs(), st.pause_duration, mk(0, 0, SL, 1, 0, 0));
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) sb_q.push_back(mk(0, 1, SL, 1, 0, 0));
    sb_q.push_back(mk(0, 1, SL, 0, 0, 0));
    sb_q.push_back(mk(0, 1, SL, 1, 0, 0));
    sb_q.push_back(mk(1, 0, R, 1, 1, 0));
    sb_q.push_back(mk(1, 0, SH, 1, 1, 0));
    sb_q.push_back(mk(0, 1, F, 1, 1, 0));
    sb_q.push_back(mk(1, 0, R, 1, 1, 0));
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i == 2) begin cvalid = 1; hr = 32'd2; lr = 32'd1; end
      if (i == 3) cvalid = 0;
      exp_v = sb_q.pop_front();
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL restart cyc %0d got %b exp %b", i, obs(), exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_even_diff();
    test_rate_one();
    test_pause();
    test_disable();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
